// File: rtl/nzcv_flag_pipe_pkg.sv
// Shared processor package: flag bit indices, flag-slot record and helpers
// used by the NZCV flag pipeline and its slot registers.
package nzcv_flag_pipe_pkg;

  // Width of every flag vector
  localparam int FLAG_W = 4;

  // Flag bit positions inside a {N,Z,C,V} vector
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  // One pipeline slot: occupancy, S-bit and the flag payload
  typedef struct packed {
    logic              valid;
    logic              set;
    logic [FLAG_W-1:0] nzcv;
  } flag_slot_t;

  // All-zero slot, used for reset and squash
  localparam flag_slot_t FLAG_SLOT_EMPTY = '{valid: 1'b0, set: 1'b0, nzcv: 4'b0000};

  // A slot only matters for commit/forwarding when it is occupied and flag-setting
  function automatic logic slot_live(input flag_slot_t slot);
    return slot.valid & slot.set;
  endfunction

  // Assemble a flag vector from individual flags in the fixed bit order
  function automatic logic [FLAG_W-1:0] pack_nzcv(input logic n, input logic z,
                                                  input logic c, input logic v);
    logic [FLAG_W-1:0] vec;
    vec        = 4'b0000;
    vec[N_BIT] = n;
    vec[Z_BIT] = z;
    vec[C_BIT] = c;
    vec[V_BIT] = v;
    return vec;
  endfunction

endpackage

// File: rtl/nzcv_flag_pipe_flag_slot.sv
// flag_slot: one registered pipeline slot (valid/set/nzcv) with clear, load
// and hold controls. Clear has priority over load.
module flag_slot
  import nzcv_flag_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       load_i,
  input  flag_slot_t slot_i,
  output flag_slot_t slot_o
);

  flag_slot_t slot_q;
  flag_slot_t slot_d;

  // Next-state selection: squash, capture new entry, or hold
  always_comb begin
    slot_d = slot_q;
    if (clear_i) begin
      slot_d = FLAG_SLOT_EMPTY;
    end else if (load_i) begin
      slot_d = slot_i;
    end else begin
      slot_d = slot_q;
    end
  end

  // Slot register, asynchronously emptied by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= FLAG_SLOT_EMPTY;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/nzcv_flag_pipe.sv
// nzcv_flag_pipe: carries ALU condition flags from EX through MEM and WB
// slots, commits them to the architectural NZCV register at WB, and offers
// an optionally forwarded flag view to the condition evaluator.
module nzcv_flag_pipe
  import nzcv_flag_pipe_pkg::*;
#(
  parameter int          FWD_EN     = 1,
  parameter logic [3:0]  RESET_NZCV = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic       ex_set_flags,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       stall,
  input  logic       flush,
  output logic       negative,
  output logic       zero,
  output logic       carry,
  output logic       overflow,
  output logic [3:0] arch_nzcv,
  output logic       flags_pending
);

  flag_slot_t  ex_slot_s;
  flag_slot_t  mem_q;
  flag_slot_t  wb_q;
  logic        advance_s;
  logic        commit_s;
  logic [3:0]  arch_nzcv_q;
  logic [3:0]  arch_nzcv_d;
  logic [3:0]  view_s;

  // Package the EX-stage ALU results into a slot record
  always_comb begin
    ex_slot_s       = FLAG_SLOT_EMPTY;
    ex_slot_s.valid = ex_valid;
    ex_slot_s.set   = ex_set_flags;
    ex_slot_s.nzcv  = pack_nzcv(alu_negative, alu_zero, alu_carry, alu_overflow);
  end

  // Pipeline control: flush beats stall, and a flush still lets WB commit
  always_comb begin
    advance_s = 1'b0;
    commit_s  = 1'b0;
    if (flush) begin
      advance_s = 1'b0;
      commit_s  = slot_live(wb_q);
    end else if (stall) begin
      advance_s = 1'b0;
      commit_s  = 1'b0;
    end else begin
      advance_s = 1'b1;
      commit_s  = slot_live(wb_q);
    end
  end

  flag_slot u_mem_slot (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush),
    .load_i  (advance_s),
    .slot_i  (ex_slot_s),
    .slot_o  (mem_q)
  );

  // The squashed MEM entry is not promoted: clearing WB on flush drops it
  flag_slot u_wb_slot (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush),
    .load_i  (advance_s),
    .slot_i  (mem_q),
    .slot_o  (wb_q)
  );

  // Architectural flag next-state: take WB payload on commit, else hold
  always_comb begin
    arch_nzcv_d = arch_nzcv_q;
    if (commit_s) begin
      arch_nzcv_d = wb_q.nzcv;
    end else begin
      arch_nzcv_d = arch_nzcv_q;
    end
  end

  // Architectural flag register, loaded with the reset value asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arch_nzcv_q <= RESET_NZCV;
    end else begin
      arch_nzcv_q <= arch_nzcv_d;
    end
  end

  generate
    if (FWD_EN != 0) begin : g_fwd
      // Forwarding mux: youngest live in-flight flags win over older ones
      always_comb begin
        view_s = arch_nzcv_q;
        if (slot_live(mem_q)) begin
          view_s = mem_q.nzcv;
        end else if (slot_live(wb_q)) begin
          view_s = wb_q.nzcv;
        end else begin
          view_s = arch_nzcv_q;
        end
      end
    end else begin : g_arch
      assign view_s = arch_nzcv_q;
    end
  endgenerate

  assign negative      = view_s[N_BIT];
  assign zero          = view_s[Z_BIT];
  assign carry         = view_s[C_BIT];
  assign overflow      = view_s[V_BIT];
  assign arch_nzcv     = arch_nzcv_q;
  assign flags_pending = slot_live(mem_q) | slot_live(wb_q);

endmodule

// File: tb/tb_nzcv_flag_pipe.sv
// Self-checking bench for nzcv_flag_pipe: directed scenarios followed by
// random traffic, compared against an in-flight-list reference model.
module tb_nzcv_flag_pipe;

  localparam logic [3:0] RST_VAL = 4'b0100;

  logic       clk;
  logic       reset;
  logic       ex_valid, ex_set_flags;
  logic       alu_negative, alu_zero, alu_carry, alu_overflow;
  logic       stall, flush;
  logic       negative, zero, carry, overflow;
  logic [3:0] arch_nzcv;
  logic       flags_pending;
  logic       a_negative, a_zero, a_carry, a_overflow;
  logic [3:0] a_arch_nzcv;
  logic       a_flags_pending;

  int total = 0;
  int bad   = 0;

  nzcv_flag_pipe #(.FWD_EN(1), .RESET_NZCV(RST_VAL)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .stall(stall), .flush(flush),
    .negative(negative), .zero(zero), .carry(carry), .overflow(overflow),
    .arch_nzcv(arch_nzcv), .flags_pending(flags_pending)
  );

  nzcv_flag_pipe #(.FWD_EN(0), .RESET_NZCV(RST_VAL)) dut_arch (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .stall(stall), .flush(flush),
    .negative(a_negative), .zero(a_zero), .carry(a_carry), .overflow(a_overflow),
    .arch_nzcv(a_arch_nzcv), .flags_pending(a_flags_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of in-flight instructions, newest first
  typedef struct {
    bit       v;
    bit       s;
    bit [3:0] f;
  } ent_t;

  ent_t     inflight[$];
  bit [3:0] m_arch;

  function automatic ent_t empty_ent();
    ent_t e;
    e.v = 1'b0; e.s = 1'b0; e.f = 4'b0000;
    return e;
  endfunction

  function automatic void m_reset();
    inflight.delete();
    inflight.push_back(empty_ent());
    inflight.push_back(empty_ent());
    m_arch = RST_VAL;
  endfunction

  function automatic void m_clock(input ent_t ex, input bit st, input bit fl);
    ent_t oldest;
    oldest = inflight[1];
    if (fl || !st) begin
      if (oldest.v && oldest.s) m_arch = oldest.f;
    end
    if (fl) begin
      inflight[0] = empty_ent();
      inflight[1] = empty_ent();
    end else if (!st) begin
      inflight.push_front(ex);
      void'(inflight.pop_back());
    end
  endfunction

  function automatic bit [3:0] m_view();
    foreach (inflight[i]) begin
      if (inflight[i].v && inflight[i].s) return inflight[i].f;
    end
    return m_arch;
  endfunction

  function automatic bit m_pending();
    foreach (inflight[i]) begin
      if (inflight[i].v && inflight[i].s) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic cmp4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cmp1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    cmp4({tag, ".view"},    {negative, zero, carry, overflow}, m_view());
    cmp4({tag, ".arch"},    arch_nzcv, m_arch);
    cmp1({tag, ".pending"}, flags_pending, m_pending());
    cmp4({tag, ".view0"},   {a_negative, a_zero, a_carry, a_overflow}, m_arch);
    cmp4({tag, ".arch0"},   a_arch_nzcv, m_arch);
  endtask

  task automatic step(input bit v, input bit s, input bit [3:0] f,
                      input bit st, input bit fl, input string tag);
    ent_t e;
    ex_valid = v; ex_set_flags = s;
    {alu_negative, alu_zero, alu_carry, alu_overflow} = f;
    stall = st; flush = fl;
    e.v = v; e.s = s; e.f = f;
    @(posedge clk);
    m_clock(e, st, fl);
    #1;
    check(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    check({tag, ".async"});
    cmp4({tag, ".async_const"}, {negative, zero, carry, overflow}, RST_VAL);
    @(posedge clk);
    #1;
    check({tag, ".held"});
    @(negedge clk);
    reset = 1'b0;
    #1;
    check({tag, ".rel"});
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 1'b0; ex_set_flags = 1'b0;
    {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b0000;
    stall = 1'b0; flush = 1'b0;
    m_reset();
    #1;
    check("rst_during");
    cmp1("rst_pending", flags_pending, 1'b0);
    @(posedge clk); #1;
    check("rst_edge");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_after");

    // Single set-flags instruction travels to commit
    step(1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, "s1_e1");
    cmp4("s1_fwd", {negative, zero, carry, overflow}, 4'b0110);
    cmp1("s1_pend1", flags_pending, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "s1_e2");
    cmp1("s1_pend2", flags_pending, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "s1_e3");
    cmp4("s1_arch", arch_nzcv, 4'b0110);
    cmp1("s1_pend3", flags_pending, 1'b0);

    // Back-to-back writers, MEM outranks WB
    step(1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, "s2_e1");
    step(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, "s2_e2");
    cmp4("s2_mem_prio", {negative, zero, carry, overflow}, 4'b0001);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "s2_e3");
    cmp4("s2_arch_mid", arch_nzcv, 4'b1000);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "s2_e4");
    cmp4("s2_arch", arch_nzcv, 4'b0001);

    // Stall freezes everything, release resumes commit
    step(1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, "s3_load");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, "s3_stall");
      cmp4("s3_frozen_arch", arch_nzcv, 4'b0001);
      cmp4("s3_frozen_view", {negative, zero, carry, overflow}, 4'b0100);
    end
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "s3_rel1");
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "s3_rel2");
    cmp4("s3_arch", arch_nzcv, 4'b0100);

    // Flush squashes MEM but lets WB commit (with stall also asserted)
    step(1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, "s4_a");
    step(1'b1, 1'b1, 4'b1001, 1'b0, 1'b0, "s4_b");
    step(1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, "s4_flush");
    cmp4("s4_arch", arch_nzcv, 4'b0010);
    cmp1("s4_pending", flags_pending, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "s4_after1");
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "s4_after2");
    cmp4("s4_no_commit", arch_nzcv, 4'b0010);

    // Non-setting instruction passes through without effect
    step(1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, "s5_e1");
    cmp1("s5_pend", flags_pending, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "s5_e2");
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "s5_e3");
    cmp4("s5_arch", arch_nzcv, 4'b0010);

    // Reset with two writers in flight discards them
    step(1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, "s6_a");
    step(1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, "s6_b");
    async_reset("s6");
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "s6_post1");
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "s6_post2");
    cmp4("s6_arch", arch_nzcv, RST_VAL);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bit       rv, rs, rst_now, fl, st;
      bit [3:0] rf;
      rv = ($urandom_range(3, 0) != 0);
      rs = ($urandom_range(2, 0) != 0);
      rf = 4'($urandom_range(15, 0));
      st = ($urandom_range(3, 0) == 0);
      fl = ($urandom_range(7, 0) == 0);
      rst_now = ($urandom_range(63, 0) == 0);
      step(rv, rs, rf, st, fl, "rnd");
      if (rst_now) async_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nzcv_flag_pipe.md
NZCV_FLAG_PIPE -- requirements
Module: nzcv_flag_pipe

Interface
REQ-001 Parameter FWD_EN, default 1, meaning: 1 = forward in-flight flags to the flag outputs; 0 = expose architectural flags only.
REQ-002 Parameter RESET_NZCV, default 4'b0000, meaning: architectural {negative, zero, carry, overflow} value loaded at reset.
REQ-003 Port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port ex_valid, input, 1, an instruction occupies EX this cycle.
REQ-006 Port ex_set_flags, input, 1, the EX instruction updates flags (S-bit).
REQ-007 Port alu_negative / alu_zero / alu_carry / alu_overflow, input, 1 each, ALU flag results of the EX instruction.
REQ-008 Port stall, input, 1, freeze the EX->MEM->WB flag pipeline.
REQ-009 Port flush, input, 1, cancel the EX and MEM flag slots (taken-branch squash).
REQ-010 Port negative / zero / carry / overflow, output, 1 each, flag view consumed by the condition evaluator.
REQ-011 Port arch_nzcv, output, 4, committed architectural flags {N,Z,C,V}.
REQ-012 Port flags_pending, output, 1, at least one valid flag-setting entry in MEM or WB slot.

Function
REQ-013 Two slot registers SHALL exist, MEM and WB, each holding valid, set, nzcv[3:0].
REQ-014 On a clock edge with stall=0 and flush=0: MEM <= {ex_valid, ex_set_flags, alu N,Z,C,V}; WB <= MEM.
REQ-015 On a clock edge with WB.valid=1, WB.set=1 and stall=0, arch_nzcv SHALL load WB.nzcv; otherwise arch_nzcv holds.
REQ-016 Latency: flags presented in EX at edge k SHALL appear in arch_nzcv after edge k+2 (three edges from EX capture, no stall).
REQ-017 With stall=1 (flush=0), MEM, WB and arch_nzcv SHALL hold their values; EX inputs are ignored.
REQ-018 With flush=1, MEM.valid SHALL load 0 and WB SHALL load 0-valid (squashed MEM entry not promoted); the current WB entry SHALL still commit per REQ-015.
REQ-019 flush=1 and stall=1 together: flush wins; WB commit proceeds as if stall=0.
REQ-020 Forwarded view (FWD_EN=1), combinational priority: MEM.nzcv if MEM.valid&MEM.set; else WB.nzcv if WB.valid&WB.set; else arch_nzcv.
REQ-021 FWD_EN=0: negative/zero/carry/overflow SHALL equal arch_nzcv bits.
REQ-022 Entries with valid=1, set=0 SHALL pass through slots but never update arch_nzcv nor be forwarded.
REQ-023 flags_pending SHALL be (MEM.valid&MEM.set)|(WB.valid&WB.set), combinational from registered state.
REQ-024 Bit order of every 4-bit flag vector SHALL be [3]=N, [2]=Z, [1]=C, [0]=V.

Reset
REQ-025 reset=1 SHALL asynchronously clear MEM and WB (valid, set, nzcv = 0) and load arch_nzcv = RESET_NZCV.
REQ-026 During and immediately after reset, flag outputs SHALL equal RESET_NZCV and flags_pending SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight entries without committing them.

Structure
REQ-028 Flag-index constants (N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0) and a flag-slot typedef/struct SHALL live in the shared processor package.
REQ-029 One sub-module, flag_slot (registered valid/set/nzcv with load, hold, clear controls), SHALL be instantiated twice for MEM and WB.
REQ-030 Outputs SHALL connect directly to the condition-evaluator flag inputs without extra logic.

Verification
REQ-031 Reset, then EX valid/set with NZCV=4'b0110, no stall -> outputs 0110 one edge later, arch_nzcv=0110 after third edge, flags_pending 1 for two cycles.
REQ-032 Back-to-back set-flags 4'b1000 then 4'b0001 -> after second edge outputs 0001 (MEM priority over WB); final arch_nzcv=0001.
REQ-033 Set-flags 4'b0100 in MEM, stall=1 for 3 cycles -> outputs, slots and arch_nzcv frozen; release -> commit resumes, arch_nzcv=0100 two edges later.
REQ-034 Set-flags 4'b0010 in WB, 4'b1001 in MEM, flush=1 -> arch_nzcv=0010, 1001 never commits, flags_pending 0 next cycle.
REQ-035 EX valid, set=0, ALU NZCV=4'b1111 -> arch_nzcv and outputs unchanged, flags_pending stays 0.
REQ-036 Reset pulsed while two set-flags entries in flight, RESET_NZCV=4'b0100 -> outputs 0100 asynchronously, no subsequent commit.
